// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter: NREQ producers share one WIDTH-bit register.
// One winner per cycle is loaded on the next edge and receives a one-cycle grant.
module dff_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [PW-1:0]         owner
);

  logic [NREQ-1:0]  gnt_r;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic [PW-1:0]    owner_r;
  logic [PW-1:0]    ptr_r;

  logic [NREQ-1:0]  elig_s;
  logic             found_s;
  logic [PW-1:0]    win_s;
  logic [PW-1:0]    ptr_nxt_s;
  logic [NREQ-1:0]  gnt_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;

  // A client granted this cycle is masked so a held req cannot double-write.
  assign elig_s = req & ~gnt_r;

  // Circular priority search starting at ptr_r, wrapping without exceeding NREQ-1.
  always_comb begin
    int idx;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[PW'(idx)]) begin
        found_s = 1'b1;
        win_s   = PW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Decode the winner into grant vector, selected data lane and next pointer.
  always_comb begin
    gnt_nxt_s  = '0;
    data_nxt_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Only the winning lane is selected, so X on other lanes never reaches q.
      if (found_s && (win_s == PW'(i))) begin
        gnt_nxt_s[i] = 1'b1;
        data_nxt_s   = wdata[i*WIDTH +: WIDTH];
      end else begin
        gnt_nxt_s[i] = 1'b0;
      end
    end
    if (win_s == PW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + PW'(1);
    end
  end

  // State registers: reset, load on a winner, otherwise hold and drop grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
      ptr_r     <= '0;
    end else if (found_s) begin
      gnt_r     <= gnt_nxt_s;
      q_r       <= data_nxt_s;
      q_valid_r <= 1'b1;
      owner_r   <= win_s;
      ptr_r     <= ptr_nxt_s;
    end else begin
      gnt_r     <= '0;
    end
  end

  assign gnt     = gnt_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign owner   = owner_r;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed self-checking bench for dff_write_arbiter (NREQ=4, WIDTH=8).
// Each check compares {gnt, q, q_valid, owner} against a hand-computed value.
module tb_dff_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] exp;
    rst = 1'b1; req = 4'b1111; wdata = 32'h13121110;
    tick(); tick();
    exp = {4'b0000, 8'h00, 1'b0, 2'd0};
    checks++;
    if ({gnt, q, q_valid, owner} !== exp) begin
      failures++;
      $display("FAIL reset: got gnt=%b q=%h v=%b o=%0d, want %b", gnt, q, q_valid, owner, exp);
    end
    rst = 1'b0;
    tick();
    exp = {4'b0001, 8'h10, 1'b1, 2'd0};
    checks++;
    if ({gnt, q, q_valid, owner} !== exp) begin
      failures++;
      $display("FAIL reset_release: got gnt=%b q=%h v=%b o=%0d, want %b", gnt, q, q_valid, owner, exp);
    end
  endtask

  task automatic test_single_write;
    logic [14:0] exp [2];
    exp[0] = {4'b0001, 8'hA5, 1'b1, 2'd0};
    exp[1] = {4'b0000, 8'hA5, 1'b1, 2'd0};
    do_reset();
    req = 4'b0001; wdata = 32'h000000A5;
    for (int k = 0; k < 2; k++) begin
      tick();
      req = 4'b0000;
      checks++;
      if ({gnt, q, q_valid, owner} !== exp[k]) begin
        failures++;
        $display("FAIL single_write[%0d]: got gnt=%b q=%h v=%b o=%0d, want %b", k, gnt, q, q_valid, owner, exp[k]);
      end
    end
  endtask

  task automatic test_rotation;
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] eq [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [1:0] eo [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111; wdata = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({gnt, q, q_valid, owner} !== {eg[k], eq[k], 1'b1, eo[k]}) begin
        failures++;
        $display("FAIL rotation[%0d]: got gnt=%b q=%h o=%0d, want gnt=%b q=%h o=%0d", k, gnt, q, owner, eg[k], eq[k], eo[k]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back;
    logic [3:0] eg [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    req = 4'b0100; wdata = 32'h003C0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({gnt, q, q_valid, owner} !== {eg[k], 8'h3C, 1'b1, 2'd2}) begin
        failures++;
        $display("FAIL mask[%0d]: got gnt=%b q=%h v=%b o=%0d, want gnt=%b q=3c o=2", k, gnt, q, q_valid, owner, eg[k]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap;
    logic [14:0] exp [3];
    exp[0] = {4'b0100, 8'h52, 1'b1, 2'd2};
    exp[1] = {4'b0001, 8'h50, 1'b1, 2'd0};
    exp[2] = {4'b0010, 8'h51, 1'b1, 2'd1};
    do_reset();
    req = 4'b0100; wdata = 32'h53525150;
    for (int k = 0; k < 3; k++) begin
      tick();
      req = 4'b0011;
      checks++;
      if ({gnt, q, q_valid, owner} !== exp[k]) begin
        failures++;
        $display("FAIL wrap[%0d]: got gnt=%b q=%h v=%b o=%0d, want %b", k, gnt, q, q_valid, owner, exp[k]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid;
    logic [14:0] exp [4];
    exp[0] = {4'b0001, 8'h10, 1'b1, 2'd0};
    exp[1] = {4'b0010, 8'h11, 1'b1, 2'd1};
    exp[2] = {4'b0000, 8'h00, 1'b0, 2'd0};
    exp[3] = {4'b0001, 8'h10, 1'b1, 2'd0};
    do_reset();
    req = 4'b1111; wdata = 32'h13121110;
    for (int k = 0; k < 4; k++) begin
      rst = (k == 2) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if ({gnt, q, q_valid, owner} !== exp[k]) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got gnt=%b q=%h v=%b o=%0d, want %b", k, gnt, q, q_valid, owner, exp[k]);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_x_lane;
    do_reset();
    req = 4'b0001; wdata = {24'hxxxxxx, 8'h77};
    tick();
    req = 4'b0000;
    checks++;
    if ({gnt, q, q_valid, owner} !== {4'b0001, 8'h77, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL x_lane: got gnt=%b q=%h v=%b o=%0d, want gnt=0001 q=77 v=1 o=0", gnt, q, q_valid, owner);
    end
    wdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; wdata = 32'h0;
    test_reset();
    test_single_write();
    test_rotation();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_x_lane();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
